// File: rtl/sat_pkg.sv
// sat_pkg: shared types and constants for the stuck-at fault tester.
//   sat_state_e : sequencer states (IDLE, APPLY, SAMPLE, DONE)
//   SAT_N_MIN/MAX : legal range of DUT input counts
//   nvec(n)       : number of vectors in a complete run (n walking zeros + all-0 + all-1)
package sat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sat_state_e;

  localparam int SAT_N_MIN = 2;
  localparam int SAT_N_MAX = 16;

  function automatic int nvec(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/stuck_at_tester_if.sv
// stuck_at_tester_if: groups the start/done handshake, the result bus and the
// DUT stimulus/response pins of the stuck-at tester.
//   master : stimulus controller + DUT side (drives start, dut_z)
//   slave  : the tester itself
// Optional macro SAT_FAIL_COUNT_EN adds the fail_cnt result field.
interface stuck_at_tester_if #(
  parameter int N = 2
);
  logic         start;
  logic         dut_z;
  logic [N-1:0] test_vec;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] sa1_mask;
  logic         sa0_det;
  logic         z_sa1;
`ifdef SAT_FAIL_COUNT_EN
  logic [$clog2(N+3)-1:0] fail_cnt;

  modport master (output start, dut_z,
                  input  test_vec, busy, done, pass, sa1_mask, sa0_det, z_sa1, fail_cnt);
  modport slave  (input  start, dut_z,
                  output test_vec, busy, done, pass, sa1_mask, sa0_det, z_sa1, fail_cnt);
`else
  modport master (output start, dut_z,
                  input  test_vec, busy, done, pass, sa1_mask, sa0_det, z_sa1);
  modport slave  (input  start, dut_z,
                  output test_vec, busy, done, pass, sa1_mask, sa0_det, z_sa1);
`endif
endinterface

// File: rtl/sat_vec_gen.sv
// sat_vec_gen: combinational vector table for an N-input AND under test.
//   k     : vector index 0..N+1
//   vec   : k=0 all zeros; k=1..N all ones with bit k-1 low; k=N+1 all ones
//   exp_z : ideal AND output for vec (only the all-ones vector yields 1)
module sat_vec_gen #(
  parameter int N  = 2,
  parameter int KW = $clog2(N + 2)
) (
  input  logic [KW-1:0] k,
  output logic [N-1:0]  vec,
  output logic          exp_z
);

  localparam logic [KW-1:0] KLAST = KW'(N + 1);

  // Bit i is low only for k=0 and for its own walking-zero index i+1.
  always_comb begin
    vec = '0;
    for (int i = 0; i < N; i++) begin
      vec[i] = (k != '0) && (k != KW'(i + 1));
    end
  end

  assign exp_z = (k == KLAST);

endmodule

// File: rtl/stuck_at_tester.sv
// stuck_at_tester: clocked stuck-at fault tester for an N-input AND gate.
// Sequences N+2 vectors onto the DUT, holds each for SETTLE cycles, samples
// dut_z one cycle later and records mismatches as a per-input stuck-at-1
// map plus output/global stuck-at flags.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stuck_at_tester_if.slave (start/dut_z in; test_vec, busy, done,
//          pass, sa1_mask, sa0_det, z_sa1 out)
// Macro SAT_FAIL_COUNT_EN: adds bus.fail_cnt, mismatches in the current run.
module stuck_at_tester
  import sat_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  stuck_at_tester_if.slave  bus
);

  localparam int KW = $clog2(N + 2);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [KW-1:0] KLAST  = KW'(nvec(N) - 1);
  localparam logic [CW-1:0] CLAST  = CW'(SETTLE - 1);

  sat_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [N-1:0]  sa1_mask_q, sa1_mask_d;
  logic          sa0_det_q, sa0_det_d;
  logic          z_sa1_q, z_sa1_d;

  logic [N-1:0]  vec;
  logic          exp_z;
  logic          busy;

  sat_vec_gen #(.N(N), .KW(KW)) u_vec_gen (
    .k     (k_q),
    .vec   (vec),
    .exp_z (exp_z)
  );

`ifdef SAT_FAIL_COUNT_EN
  localparam int FW = $clog2(N + 3);
  localparam logic [FW-1:0] FMAX = FW'(nvec(N));
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    sa1_mask_d = sa1_mask_q;
    sa0_det_d  = sa0_det_q;
    z_sa1_d    = z_sa1_q;
`ifdef SAT_FAIL_COUNT_EN
    fail_cnt_d = fail_cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = APPLY;
          k_d        = '0;
          cnt_d      = '0;
          pass_d     = 1'b0;
          sa1_mask_d = '0;
          sa0_det_d  = 1'b0;
          z_sa1_d    = 1'b0;
`ifdef SAT_FAIL_COUNT_EN
          fail_cnt_d = '0;
`endif
        end
      end
      APPLY: begin
        if (cnt_q == CLAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.dut_z != exp_z) begin
          if (k_q == '0)        z_sa1_d   = 1'b1;
          else if (k_q == KLAST) sa0_det_d = 1'b1;
          else begin
            for (int i = 0; i < N; i++) begin
              if (k_q == KW'(i + 1)) sa1_mask_d[i] = 1'b1;
            end
          end
`ifdef SAT_FAIL_COUNT_EN
          if (fail_cnt_q != FMAX) fail_cnt_d = fail_cnt_q + 1'b1;
`endif
        end
        if (k_q == KLAST) begin
          // Fold in this last sample so pass is correct on the done cycle.
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = ~(z_sa1_d | sa0_det_d | (|sa1_mask_d));
        end else begin
          state_d = APPLY;
          k_d     = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      sa1_mask_q <= '0;
      sa0_det_q  <= 1'b0;
      z_sa1_q    <= 1'b0;
`ifdef SAT_FAIL_COUNT_EN
      fail_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      sa1_mask_q <= sa1_mask_d;
      sa0_det_q  <= sa0_det_d;
      z_sa1_q    <= z_sa1_d;
`ifdef SAT_FAIL_COUNT_EN
      fail_cnt_q <= fail_cnt_d;
`endif
    end
  end

  assign busy         = (state_q == APPLY) || (state_q == SAMPLE);
  assign bus.busy     = busy;
  assign bus.test_vec = busy ? vec : '0;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.sa1_mask = sa1_mask_q;
  assign bus.sa0_det  = sa0_det_q;
  assign bus.z_sa1    = z_sa1_q;
`ifdef SAT_FAIL_COUNT_EN
  assign bus.fail_cnt = fail_cnt_q;
`endif

endmodule
